q_relay_pipe: RTL and testbench

- Parametrised pipelined stream interconnect. Forward path (data, valid) and backward path (back-pressure) are both registered in every stage.
- Unlike a forward-only pipe, back-pressure is not passed through combinationally. Each stage is a 2-entry relay (skid) station, so long interconnect can be retimed in both directions.
- Sits between stream producer and consumer queues on long or inter-partition routes.

---
 rtl/q_relay_pipe_pkg.sv | 18 +
 rtl/q_relay_pipe_stage.sv | 93 +++++++++
 rtl/q_relay_pipe.sv | 74 +++++++
 tb/tb_q_relay_pipe.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/q_relay_pipe_pkg.sv
// Shared constants, relay-station occupancy encoding and occupancy-width helper for q_relay_pipe.
package q_relay_pipe_pkg;

  localparam logic B_RESET   = 1'b1;
  localparam logic V_RESET   = 1'b0;
  localparam int   MAX_DEPTH = 256;

  typedef enum logic [1:0] {
    CNT_EMPTY = 2'd0,
    CNT_ONE   = 2'd1,
    CNT_TWO   = 2'd2
  } relay_cnt_e;

  function automatic int occ_width(input int depth);
    return $clog2(2 * depth + 1);
  endfunction

endpackage

// File: rtl/q_relay_pipe_stage.sv
// q_relay_stage: one 2-entry relay (skid) station; valid and back-pressure both leave from flops.
//  state     | meaning
//  CNT_EMPTY | no token held, out_v=0
//  CNT_ONE   | token in head register H
//  CNT_TWO   | H plus skid token in A, in_b asserted
module q_relay_stage
  import q_relay_pipe_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_d,
  input  logic             in_v,
  output logic             in_b,
  output logic [WIDTH-1:0] out_d,
  output logic             out_v,
  input  logic             out_b
);

  relay_cnt_e       r_cnt;
  relay_cnt_e       w_cnt_next;
  logic [WIDTH-1:0] r_h;
  logic [WIDTH-1:0] r_a;
  logic             r_bq;
  logic             w_push;
  logic             w_pop;
  logic             w_load_h_in;
  logic             w_load_h_a;
  logic             w_load_a;

  assign w_push = in_v & ~r_bq;
  assign w_pop  = (r_cnt != CNT_EMPTY) & ~out_b;

  always_comb begin
    w_cnt_next  = r_cnt;
    w_load_h_in = 1'b0;
    w_load_h_a  = 1'b0;
    w_load_a    = 1'b0;
    case (r_cnt)
      CNT_EMPTY: begin
        if (w_push) begin
          w_cnt_next  = CNT_ONE;
          w_load_h_in = 1'b1;
        end
      end
      CNT_ONE: begin
        if (w_push && w_pop) begin
          w_load_h_in = 1'b1;
        end else if (w_push) begin
          w_cnt_next = CNT_TWO;
          w_load_a   = 1'b1;
        end else if (w_pop) begin
          w_cnt_next = CNT_EMPTY;
        end
      end
      CNT_TWO: begin
        // push cannot happen here: bq is already high
        if (w_pop) begin
          w_cnt_next = CNT_ONE;
          w_load_h_a = 1'b1;
        end
      end
      default: w_cnt_next = CNT_EMPTY;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt <= CNT_EMPTY;
      r_bq  <= B_RESET;
    end else begin
      r_cnt <= w_cnt_next;
      r_bq  <= (w_cnt_next == CNT_TWO);
    end
  end

  always_ff @(posedge clock) begin
    if (w_load_h_in) begin
      r_h <= in_d;
    end else if (w_load_h_a) begin
      r_h <= r_a;
    end
    if (w_load_a) begin
      r_a <= in_d;
    end
  end

  assign in_b  = r_bq;
  assign out_d = r_h;
  assign out_v = (r_cnt != CNT_EMPTY);

endmodule

// File: rtl/q_relay_pipe.sv
// q_relay_pipe: DEPTH chained relay stations, registered in both directions.
// Define Q_RELAY_PIPE_OCC_EN to add the o_occ total-occupancy output.
module q_relay_pipe
  import q_relay_pipe_pkg::*;
#(
  parameter int DEPTH = 1,
  parameter int WIDTH = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [WIDTH-1:0]              i_d,
  input  logic                          i_v,
  output logic                          i_b,
  output logic [WIDTH-1:0]              o_d,
  output logic                          o_v,
  input  logic                          o_b
`ifdef Q_RELAY_PIPE_OCC_EN
  ,
  output logic [occ_width(DEPTH)-1:0]   o_occ
`endif
);

  if (DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_bad_depth
    $error("q_relay_pipe: DEPTH out of range");
  end

  logic [WIDTH-1:0] w_d [DEPTH+1];
  logic             w_v [DEPTH+1];
  logic             w_b [DEPTH+1];

  assign w_d[0]     = i_d;
  assign w_v[0]     = i_v;
  assign i_b        = w_b[0];
  assign o_d        = w_d[DEPTH];
  assign o_v        = w_v[DEPTH];
  assign w_b[DEPTH] = o_b;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    q_relay_stage #(.WIDTH(WIDTH)) u_stage (
      .clock (clock),
      .reset (reset),
      .in_d  (w_d[k]),
      .in_v  (w_v[k]),
      .in_b  (w_b[k]),
      .out_d (w_d[k+1]),
      .out_v (w_v[k+1]),
      .out_b (w_b[k+1])
    );
  end

`ifdef Q_RELAY_PIPE_OCC_EN
  localparam int OW = occ_width(DEPTH);

  logic          w_in_xfer;
  logic          w_out_xfer;
  logic [OW-1:0] r_occ;

  assign w_in_xfer  = i_v & ~w_b[0];
  assign w_out_xfer = w_v[DEPTH] & ~o_b;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_occ <= '0;
    end else if (w_in_xfer && !w_out_xfer) begin
      r_occ <= r_occ + OW'(1);
    end else if (!w_in_xfer && w_out_xfer) begin
      r_occ <= r_occ - OW'(1);
    end
  end

  assign o_occ = r_occ;
`endif

endmodule

// File: tb/tb_q_relay_pipe.sv
// Bench for q_relay_pipe: directed vectors on a DEPTH=4 pipe plus queue-model random runs at DEPTH 1 and 7.
// Build with +define+Q_RELAY_PIPE_OCC_EN to also check o_occ.
module tb_q_relay_pipe;
  import q_relay_pipe_pkg::*;

  localparam int MD   = 4;
  localparam int W    = 8;
  localparam int CAP  = 2 * MD;
  localparam int NTOK = 10000;

  logic         clock = 1'b0;
  logic         rst_b;
  logic         rst_r;
  logic [W-1:0] i_d;
  logic         i_v;
  logic         i_b;
  logic [W-1:0] o_d;
  logic         o_v;
  logic         o_b;
`ifdef Q_RELAY_PIPE_OCC_EN
  logic [occ_width(MD)-1:0] occ;
`endif

  int n_tot = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  q_relay_pipe #(.DEPTH(MD), .WIDTH(W)) u_dut (
    .clock (clock),
    .reset (rst_b),
    .i_d   (i_d),
    .i_v   (i_v),
    .i_b   (i_b),
    .o_d   (o_d),
    .o_v   (o_v),
    .o_b   (o_b)
`ifdef Q_RELAY_PIPE_OCC_EN
    ,
    .o_occ (occ)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tot++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Random runs against a plain FIFO model: tokens in at accepted input, out in the same order.
  for (genvar g = 0; g < 2; g++) begin : g_rnd
    localparam int D = (g == 0) ? 1 : 7;
    logic [15:0] d_i;
    logic [15:0] d_o;
    logic        v_i;
    logic        b_i;
    logic        v_o;
    logic        b_o;
`ifdef Q_RELAY_PIPE_OCC_EN
    logic [occ_width(D)-1:0] occ_g;
`endif
    int total = 0;
    int bad   = 0;
    bit done  = 1'b0;

    q_relay_pipe #(.DEPTH(D), .WIDTH(16)) u_dut (
      .clock (clock),
      .reset (rst_r),
      .i_d   (d_i),
      .i_v   (v_i),
      .i_b   (b_i),
      .o_d   (d_o),
      .o_v   (v_o),
      .o_b   (b_o)
`ifdef Q_RELAY_PIPE_OCC_EN
      ,
      .o_occ (occ_g)
`endif
    );

    task automatic rchk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
        bad++;
        $display("FAIL %s D=%0d: got %0h expected %0h", nm, D, act, req);
      end
    endtask

    initial begin
      logic [15:0] q[$];
      int sent;
      int got;
      int c;
      v_i = 1'b0; d_i = '0; b_o = 1'b0; sent = 0; got = 0;
      for (c = 0; c < 20 && !rst_r; c++) @(negedge clock);
      @(negedge clock);
      for (c = 0; c < 40000 && got < NTOK; c++) begin
        @(negedge clock);
        if (!(v_i && b_i)) begin
          v_i = (sent < NTOK) && ($urandom_range(0, 3) != 0);
          d_i = {sent[7:0], 8'($urandom)};
        end
        b_o = ($urandom_range(0, 1) == 1);
        #1;
`ifdef Q_RELAY_PIPE_OCC_EN
        rchk("rnd_occ", occ_g, q.size());
`endif
        if (v_o && !b_o) begin
          if (q.size() == 0) rchk("rnd_spurious_ov", v_o, 0);
          else rchk("rnd_order", d_o, q.pop_front());
          got++;
        end
        if (v_i && !b_i) begin
          q.push_back(d_i);
          sent++;
        end
        if (q.size() > 2 * D) rchk("rnd_capacity", q.size(), 2 * D);
      end
      rchk("rnd_count", got, NTOK);
      rchk("rnd_left", q.size(), 0);
      done = 1'b1;
    end
  end

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         ob;
    logic         eb;
    logic         eo;
    logic [W-1:0] ed;
  } vec_t;

  vec_t tv[11];

  initial begin
    int nxt_in;
    int nxt_out;
    int held;
    int full_cyc;
    int ib_cyc;
    int rel_out;
    int sent;
    logic         ib0;
    logic         ov0;
    logic [W-1:0] od0;

    //          v     d      o_b   i_b   o_v   o_d   (i_b/o_v/o_d after the edge)
    tv[0]  = '{1'b1, 8'hA1, 1'b0, 1'b0, 1'b0, 8'h00};
    tv[1]  = '{1'b1, 8'hA1, 1'b0, 1'b0, 1'b0, 8'h00};
    tv[2]  = '{1'b1, 8'hA2, 1'b0, 1'b0, 1'b0, 8'h00};
    tv[3]  = '{1'b1, 8'hA3, 1'b0, 1'b0, 1'b0, 8'h00};
    tv[4]  = '{1'b1, 8'hA4, 1'b0, 1'b0, 1'b1, 8'hA1};
    tv[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA1};
    tv[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA1};
    tv[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA2};
    tv[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA3};
    tv[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA4};
    tv[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};

    rst_b = 1'b0; rst_r = 1'b0; i_v = 1'b0; i_d = '0; o_b = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    chk("reset_ib", i_b, 1);
    chk("reset_ov", o_v, 0);
`ifdef Q_RELAY_PIPE_OCC_EN
    chk("reset_occ", occ, 0);
`endif
    rst_b = 1'b1; rst_r = 1'b1;
    #1 chk("release_ib_before_edge", i_b, 1);

    for (int k = 0; k < 11; k++) begin
      i_v = tv[k].v; i_d = tv[k].d; o_b = tv[k].ob;
      @(posedge clock); #1;
      chk("vec_ib", i_b, tv[k].eb);
      chk("vec_ov", o_v, tv[k].eo);
      if (tv[k].eo) chk("vec_od", o_d, tv[k].ed);
      @(negedge clock);
    end

    // back-to-back stream: token k visible DEPTH cycles after it was offered
    for (int c = 0; c < 16 + MD + 2; c++) begin
      chk("lat_ib", i_b, 0);
      chk("lat_ov", o_v, (c >= MD && c < 16 + MD));
      if (c >= MD && c < 16 + MD) chk("lat_od", o_d, c - MD + 1);
      i_v = (c < 16); i_d = W'(c + 1); o_b = 1'b0;
      @(negedge clock);
    end

    // stall with o_b, fill to capacity, release and drain
    nxt_in = 32; nxt_out = 32; held = 0; full_cyc = -1; ib_cyc = -1; rel_out = 0;
    for (int c = 0; c < 120; c++) begin
      i_v = (c < 80); i_d = W'(nxt_in); o_b = (c >= 10 && c < 50);
      #1;
`ifdef Q_RELAY_PIPE_OCC_EN
      chk("bp_occ", occ, held);
`endif
      if (full_cyc >= 0 && ib_cyc < 0 && i_b) ib_cyc = c;
      if (o_v && !o_b) begin
        chk("bp_od", o_d, W'(nxt_out));
        nxt_out++;
        held--;
      end
      if (i_v && !i_b) begin
        nxt_in++;
        held++;
      end
      if (held == CAP && full_cyc < 0) full_cyc = c;
      if (c == 49) begin
        chk("bp_held", held, CAP);
        chk("bp_ib_full", i_b, 1);
        chk("bp_ov_full", o_v, 1);
      end
      if (c == 50) rel_out = nxt_out;
      @(negedge clock);
    end
    chk("bp_ib_latency", (ib_cyc > full_cyc) && (ib_cyc - full_cyc <= MD), 1);
    chk("bp_resume", (nxt_out - rel_out) > CAP, 1);
    chk("bp_drained", nxt_out, nxt_in);
    chk("bp_empty_ov", o_v, 0);

    // asynchronous reset with five tokens in flight
    o_b = 1'b1; sent = 0;
    for (int c = 0; c < 20 && sent < 5; c++) begin
      i_v = 1'b1; i_d = W'(8'h50 + sent);
      #1;
      if (!i_b) sent++;
      @(negedge clock);
    end
    i_v = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_tokens_sent", sent, 5);
    chk("rst_pre_ov", o_v, 1);
    #2 rst_b = 1'b0;
    #1;
    chk("rst_async_ov", o_v, 0);
    chk("rst_async_ib", i_b, 1);
`ifdef Q_RELAY_PIPE_OCC_EN
    chk("rst_async_occ", occ, 0);
`endif
    @(posedge clock); #1 chk("rst_hold_ib", i_b, 1);
    @(negedge clock);
    rst_b = 1'b1; o_b = 1'b0; i_v = 1'b0;
    #1 chk("rst_rel_ib", i_b, 1);
    @(posedge clock); #1 chk("rst_rel_ib_next", i_b, 0);
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      chk("rst_no_stale", o_v, 0);
    end

    // i_b and o_v/o_d move only on clock edges
    o_b = 1'b1; i_v = 1'b1; i_d = 8'h77;
    repeat (3 * MD + 4) @(negedge clock);
    chk("struct_full_ib", i_b, 1);
    for (int c = 0; c < 8; c++) begin
      o_b = (c % 2 == 1);
      ib0 = i_b; ov0 = o_v; od0 = o_d;
      #1;
      o_b = ~o_b;
      #1 chk("struct_ob_toggle", i_b, ib0);
      o_b = ~o_b;
      #1 chk("struct_ob_restore", i_b, ib0);
      i_v = 1'b0; i_d = ~i_d;
      #1;
      chk("struct_fwd_v", o_v, ov0);
      chk("struct_fwd_d", o_d, od0);
      i_v = 1'b1; i_d = ~i_d;
      @(negedge clock);
    end

`ifdef Q_RELAY_PIPE_OCC_EN
    rst_b = 1'b0; i_v = 1'b0; o_b = 1'b1;
    @(negedge clock);
    rst_b = 1'b1;
    @(negedge clock);
    sent = 0;
    for (int c = 0; c < 40 && sent < CAP; c++) begin
      i_v = 1'b1; i_d = W'(c);
      #1;
      if (!i_b) sent++;
      @(negedge clock);
    end
    i_v = 1'b0;
    @(negedge clock);
    chk("occ_sent", sent, CAP);
    chk("occ_full", occ, CAP);
    chk("occ_full_ib", i_b, 1);
    o_b = 1'b0;
    @(negedge clock);
    o_b = 1'b1;
    #1 chk("occ_pop", occ, CAP - 1);
    rst_b = 1'b0;
    #1 chk("occ_reset", occ, 0);
    @(negedge clock);
    rst_b = 1'b1;
`endif

    for (int c = 0; c < 50000 && !(g_rnd[0].done && g_rnd[1].done); c++) @(negedge clock);
    chk("rnd_finished", g_rnd[0].done && g_rnd[1].done, 1);
    n_tot += g_rnd[0].total + g_rnd[1].total;
    n_bad += g_rnd[0].bad + g_rnd[1].bad;
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
